// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave
//  Description : Mode-0 SPI target with one-entry TX/RX holding registers;
//                byte mode (MSB first) or 32-bit word mode (LSByte first).
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave #(
    parameter int SYNC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fast,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        SS,
    output logic        MISO,
    input  logic [31:0] dataTx,
    input  logic        wrTx,
    output logic        txEmpty,
    output logic [31:0] dataRx,
    output logic        rdy,
    input  logic        rdRx,
    output logic        ovr,
    output logic        busy
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_SHIFT = 2'd2;

    localparam int                 c_ARM_W   = $clog2(SYNC + 2);
    localparam logic [c_ARM_W-1:0] c_ARM_MAX = c_ARM_W'(SYNC + 1);

    logic [SYNC-1:0]    r_sclk_sync;
    logic [SYNC-1:0]    r_mosi_sync;
    logic [SYNC-1:0]    r_ss_sync;
    logic               r_sclk_d;
    logic               r_ss_d;
    logic [c_ARM_W-1:0] r_arm_cnt;
    logic               r_armed;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [4:0]  r_bitcnt;
    logic        r_fast;
    logic [31:0] r_shift;
    logic [31:0] r_tx_hold;
    logic        r_tx_empty;
    logic [31:0] r_rx;
    logic [31:0] r_data_rx;
    logic        r_rdy;
    logic        r_ovr;

    logic        w_sclk;
    logic        w_ss;
    logic        w_mosi;
    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic        w_ss_fall;
    logic        w_shift_act;
    logic        w_rx_rise;
    logic        w_tx_fall;
    logic        w_last;
    logic        w_word_done;
    logic        w_reload;
    logic [4:0]  w_idx;
    logic [31:0] w_rx_next;
    logic [31:0] w_rx_word;

    // ------------------------------------------------------------------
    // Input synchronizers plus one edge-detect stage on SCLK and SS
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '1;
            r_ss_sync   <= '1;
            r_sclk_d    <= 1'b0;
            r_ss_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC-2:0], SCLK};
            r_mosi_sync <= {r_mosi_sync[SYNC-2:0], MOSI};
            r_ss_sync   <= {r_ss_sync[SYNC-2:0], SS};
            r_sclk_d    <= r_sclk_sync[SYNC-1];
            r_ss_d      <= r_ss_sync[SYNC-1];
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC-1];
    assign w_ss        = r_ss_sync[SYNC-1];
    assign w_mosi      = r_mosi_sync[SYNC-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_ss_fall   = r_armed & ~w_ss & r_ss_d;

    // The SS chain resets high, so a pin held low at reset release would
    // look like a falling edge. Only arm once the flushed chain shows SS high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_arm_cnt <= '0;
            r_armed   <= 1'b0;
        end else begin
            if (r_arm_cnt != c_ARM_MAX)
                r_arm_cnt <= r_arm_cnt + 1'b1;
            if (r_arm_cnt == c_ARM_MAX && w_ss)
                r_armed <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= c_IDLE;
        else
            r_state <= w_state_next;
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_ss_fall) w_state_next = c_LOAD;
            c_LOAD:  w_state_next = w_ss ? c_IDLE : c_SHIFT;
            c_SHIFT: if (w_ss) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // FSM: outputs and datapath strobes
    always_comb begin
        w_shift_act = (r_state == c_SHIFT) && !w_ss;
        w_rx_rise   = w_shift_act && w_sclk_rise;
        w_tx_fall   = w_shift_act && w_sclk_fall;
        w_word_done = w_rx_rise && w_last;
        w_reload    = (r_state == c_LOAD) || (w_tx_fall && w_last);
        busy        = w_shift_act;
        MISO        = w_shift_act ? r_shift[w_idx] : 1'b1;
    end

    // Bit i lives at byte i[4:3] (word mode only), bit 7-i[2:0]
    assign w_idx  = {(r_fast ? r_bitcnt[4:3] : 2'b00), ~r_bitcnt[2:0]};
    assign w_last = (r_bitcnt == (r_fast ? 5'd31 : 5'd7));

    always_comb begin
        w_rx_next        = r_rx;
        w_rx_next[w_idx] = w_mosi;
    end

    assign w_rx_word = r_fast ? w_rx_next : {24'h000000, w_rx_next[7:0]};

    // ------------------------------------------------------------------
    // Shift datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bitcnt <= 5'd0;
            r_fast   <= 1'b0;
            r_shift  <= '1;
            r_rx     <= '0;
        end else begin
            if (r_state == c_LOAD) begin
                r_bitcnt <= 5'd0;
                r_fast   <= fast;
                r_rx     <= '0;
            end else begin
                if (w_tx_fall)
                    r_bitcnt <= w_last ? 5'd0 : r_bitcnt + 5'd1;
                if (w_rx_rise)
                    r_rx <= w_rx_next;
            end
            if (w_reload)
                r_shift <= r_tx_empty ? 32'hFFFF_FFFF : r_tx_hold;
        end
    end

    // TX holding register: a host write in the reload cycle lands after
    // the reload has taken the previous contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_hold  <= 32'hFFFF_FFFF;
            r_tx_empty <= 1'b1;
        end else if (wrTx) begin
            r_tx_hold  <= dataTx;
            r_tx_empty <= 1'b0;
        end else if (w_reload) begin
            r_tx_empty <= 1'b1;
        end
    end

    // RX holding register; a read coincident with completion frees the slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_rx <= '0;
            r_rdy     <= 1'b0;
            r_ovr     <= 1'b0;
        end else if (w_word_done) begin
            if (!r_rdy || rdRx) begin
                r_data_rx <= w_rx_word;
                r_rdy     <= 1'b1;
                r_ovr     <= r_ovr & ~rdRx;
            end else begin
                r_ovr     <= 1'b1;
            end
        end else if (rdRx) begin
            r_rdy <= 1'b0;
            r_ovr <= 1'b0;
        end
    end

    assign txEmpty = r_tx_empty;
    assign dataRx  = r_data_rx;
    assign rdy     = r_rdy;
    assign ovr     = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave
//  Description : Directed self-checking bench for spi_slave.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    localparam int SYNC = 2;
    localparam int HALF = 8;

    logic        clk    = 1'b0;
    logic        rst    = 1'b0;
    logic        fast   = 1'b0;
    logic        SCLK   = 1'b0;
    logic        MOSI   = 1'b1;
    logic        SS     = 1'b1;
    logic [31:0] dataTx = 32'h0;
    logic        wrTx   = 1'b0;
    logic        rdRx   = 1'b0;
    logic        MISO;
    logic        txEmpty;
    logic [31:0] dataRx;
    logic        rdy;
    logic        ovr;
    logic        busy;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] cap   = 32'h0;

    spi_slave #(.SYNC(SYNC)) dut (
        .clk(clk), .rst(rst), .fast(fast), .SCLK(SCLK), .MOSI(MOSI), .SS(SS),
        .MISO(MISO), .dataTx(dataTx), .wrTx(wrTx), .txEmpty(txEmpty),
        .dataRx(dataRx), .rdy(rdy), .rdRx(rdRx), .ovr(ovr), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Wire position of serial bit i: byte i/8, bit 7 - i%8
    function automatic int bitpos(input int i);
        return (i / 8) * 8 + 7 - (i % 8);
    endfunction

    task automatic host_write(input logic [31:0] d);
        @(negedge clk); dataTx = d; wrTx = 1'b1;
        @(negedge clk); wrTx = 1'b0;
    endtask

    task automatic host_read();
        @(negedge clk); rdRx = 1'b1;
        @(negedge clk); rdRx = 1'b0;
    endtask

    // One SCLK period; optional strobes land exactly in the DUT's edge-action cycle
    task automatic sclk_bit(input int pos, input logic [31:0] mosi_w,
                            input logic rd_strobe, input logic wr_strobe,
                            input logic [31:0] wr_data);
        MOSI = mosi_w[pos];
        repeat (HALF) @(negedge clk);
        cap[pos] = MISO;
        SCLK = 1'b1;
        if (rd_strobe) begin
            repeat (SYNC) @(negedge clk);
            rdRx = 1'b1;
            @(negedge clk); rdRx = 1'b0;
            repeat (HALF - SYNC - 1) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        SCLK = 1'b0;
        if (wr_strobe) begin
            repeat (SYNC) @(negedge clk);
            dataTx = wr_data; wrTx = 1'b1;
            @(negedge clk); wrTx = 1'b0;
            repeat (HALF - SYNC - 1) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic xfer(input int first, input int count, input logic [31:0] mosi_w,
                        input logic rd_last, input logic wr_last, input logic [31:0] wr_data);
        for (int i = first; i < first + count; i++)
            sclk_bit(bitpos(i), mosi_w, rd_last && (i == first + count - 1),
                     wr_last && (i == first + count - 1), wr_data);
    endtask

    task automatic ss_low();
        SS = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic ss_high();
        SS = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        n_vec++; if (txEmpty !== 1'b1) begin n_err++; $display("FAIL rst_txEmpty: got %b want 1", txEmpty); end
        n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL rst_rdy: got %b want 0", rdy); end
        n_vec++; if (ovr !== 1'b0) begin n_err++; $display("FAIL rst_ovr: got %b want 0", ovr); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (MISO !== 1'b1) begin n_err++; $display("FAIL rst_MISO: got %b want 1", MISO); end
        n_vec++; if (dataRx !== 32'h0) begin n_err++; $display("FAIL rst_dataRx: got %h want 00000000", dataRx); end
        @(negedge clk); rst = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_byte();
        host_write(32'h0000_00A5);
        n_vec++; if (txEmpty !== 1'b0) begin n_err++; $display("FAIL byte_txfull: got %b want 0", txEmpty); end
        fast = 1'b0;
        ss_low();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL byte_busy: got %b want 1", busy); end
        xfer(0, 8, 32'h0000_003C, 1'b0, 1'b0, 32'h0);
        ss_high();
        n_vec++; if (cap[7:0] !== 8'hA5) begin n_err++; $display("FAIL byte_miso: got %h want a5", cap[7:0]); end
        n_vec++; if (dataRx !== 32'h0000_003C) begin n_err++; $display("FAIL byte_dataRx: got %h want 0000003c", dataRx); end
        n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL byte_rdy: got %b want 1", rdy); end
        n_vec++; if (txEmpty !== 1'b1) begin n_err++; $display("FAIL byte_txEmpty: got %b want 1", txEmpty); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL byte_idle: got %b want 0", busy); end
    endtask

    task automatic test_fast();
        host_read();
        host_write(32'h1122_3344);
        fast = 1'b1;
        ss_low();
        fast = 1'b0;
        xfer(0, 32, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        ss_high();
        n_vec++; if (cap !== 32'h1122_3344) begin n_err++; $display("FAIL fast_miso: got %h want 11223344", cap); end
        n_vec++; if (dataRx !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL fast_dataRx: got %h want deadbeef", dataRx); end
        n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL fast_rdy: got %b want 1", rdy); end
    endtask

    task automatic test_back_to_back();
        host_read();
        n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL b2b_rdclr: got %b want 0", rdy); end
        ss_low();
        xfer(0, 8, 32'h01, 1'b0, 1'b0, 32'h0);
        n_vec++; if (cap[7:0] !== 8'hFF) begin n_err++; $display("FAIL b2b_miso1: got %h want ff", cap[7:0]); end
        n_vec++; if (dataRx !== 32'h01 || rdy !== 1'b1) begin n_err++; $display("FAIL b2b_rx1: got %h/%b want 00000001/1", dataRx, rdy); end
        xfer(0, 8, 32'h02, 1'b0, 1'b0, 32'h0);
        ss_high();
        n_vec++; if (cap[7:0] !== 8'hFF) begin n_err++; $display("FAIL b2b_miso2: got %h want ff", cap[7:0]); end
        n_vec++; if (dataRx !== 32'h01) begin n_err++; $display("FAIL b2b_keep: got %h want 00000001", dataRx); end
        n_vec++; if (ovr !== 1'b1) begin n_err++; $display("FAIL b2b_ovr: got %b want 1", ovr); end
        host_read();
        n_vec++; if (rdy !== 1'b0 || ovr !== 1'b0) begin n_err++; $display("FAIL b2b_clear: got rdy=%b ovr=%b want 0/0", rdy, ovr); end
    endtask

    task automatic test_abort();
        ss_low();
        xfer(0, 2, 32'h55, 1'b0, 1'b0, 32'h0);
        MOSI = 1'b0;
        repeat (HALF) @(negedge clk);
        SCLK = 1'b1;
        repeat (HALF) @(negedge clk);
        SS = 1'b1;
        repeat (SYNC + 2) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_vec++; if (MISO !== 1'b1) begin n_err++; $display("FAIL abort_MISO: got %b want 1", MISO); end
        SCLK = 1'b0;
        repeat (HALF) @(negedge clk);
        n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL abort_rdy: got %b want 0", rdy); end
        host_write(32'h6D);
        ss_low();
        xfer(0, 8, 32'hB4, 1'b0, 1'b0, 32'h0);
        ss_high();
        n_vec++; if (cap[7:0] !== 8'h6D) begin n_err++; $display("FAIL abort_next_miso: got %h want 6d", cap[7:0]); end
        n_vec++; if (dataRx !== 32'hB4) begin n_err++; $display("FAIL abort_next_rx: got %h want 000000b4", dataRx); end
        host_read();
    endtask

    // Leaves SS low and a word in progress for the async reset test
    task automatic test_collision();
        host_write(32'h5A);
        ss_low();
        xfer(0, 4, 32'h81, 1'b0, 1'b0, 32'h0);
        host_write(32'hC3);
        xfer(4, 4, 32'h81, 1'b0, 1'b1, 32'h96);
        n_vec++; if (cap[7:0] !== 8'h5A) begin n_err++; $display("FAIL coll_miso1: got %h want 5a", cap[7:0]); end
        n_vec++; if (txEmpty !== 1'b0) begin n_err++; $display("FAIL coll_held: got %b want 0", txEmpty); end
        n_vec++; if (dataRx !== 32'h81 || rdy !== 1'b1) begin n_err++; $display("FAIL coll_rx1: got %h/%b want 00000081/1", dataRx, rdy); end
        xfer(0, 8, 32'h42, 1'b1, 1'b0, 32'h0);
        n_vec++; if (cap[7:0] !== 8'hC3) begin n_err++; $display("FAIL coll_miso2: got %h want c3", cap[7:0]); end
        n_vec++; if (dataRx !== 32'h42 || rdy !== 1'b1) begin n_err++; $display("FAIL coll_rx2: got %h/%b want 00000042/1", dataRx, rdy); end
        n_vec++; if (ovr !== 1'b0) begin n_err++; $display("FAIL coll_noovr: got %b want 0", ovr); end
        n_vec++; if (txEmpty !== 1'b1) begin n_err++; $display("FAIL coll_consumed: got %b want 1", txEmpty); end
        xfer(0, 8, 32'h00, 1'b0, 1'b0, 32'h0);
        n_vec++; if (cap[7:0] !== 8'h96) begin n_err++; $display("FAIL coll_miso3: got %h want 96", cap[7:0]); end
        n_vec++; if (ovr !== 1'b1) begin n_err++; $display("FAIL coll_ovr: got %b want 1", ovr); end
    endtask

    task automatic test_async_reset();
        host_write(32'h77);
        xfer(0, 3, 32'hFF, 1'b0, 1'b0, 32'h0);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL areset_pre_busy: got %b want 1", busy); end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_vec++; if (txEmpty !== 1'b1) begin n_err++; $display("FAIL areset_txEmpty: got %b want 1", txEmpty); end
        n_vec++; if (rdy !== 1'b0 || ovr !== 1'b0) begin n_err++; $display("FAIL areset_rdy_ovr: got %b/%b want 0/0", rdy, ovr); end
        n_vec++; if (busy !== 1'b0 || MISO !== 1'b1) begin n_err++; $display("FAIL areset_busy_miso: got %b/%b want 0/1", busy, MISO); end
        n_vec++; if (dataRx !== 32'h0) begin n_err++; $display("FAIL areset_dataRx: got %h want 00000000", dataRx); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL areset_no_start: got %b want 0", busy); end
        xfer(0, 8, 32'h00, 1'b0, 1'b0, 32'h0);
        n_vec++; if (cap[7:0] !== 8'hFF || rdy !== 1'b0) begin n_err++; $display("FAIL areset_idle_xfer: got miso=%h rdy=%b want ff/0", cap[7:0], rdy); end
        ss_high();
        host_write(32'h3C);
        ss_low();
        xfer(0, 8, 32'hA5, 1'b0, 1'b0, 32'h0);
        ss_high();
        n_vec++; if (cap[7:0] !== 8'h3C || dataRx !== 32'hA5) begin n_err++; $display("FAIL areset_recover: got miso=%h rx=%h want 3c/000000a5", cap[7:0], dataRx); end
    endtask

    initial begin
        test_reset();
        test_byte();
        test_fast();
        test_back_to_back();
        test_abort();
        test_collision();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
